// File: rtl/pseudo_softmax_pkg.sv
// pseudo_softmax_pkg: shared states, term format and the base-2 piecewise-linear exponential.
package pseudo_softmax_pkg;
  typedef enum logic [1:0] {LOAD, SUM, DIV, OUT} state_t;
  localparam int unsigned ONE = 32768;
  localparam int TERM_W = 16;
  // Q1.15 approximation of 2^-(d / 2^frac): linear between integer powers, flushed to zero past 2^-15.
  function automatic logic [TERM_W-1:0] pwl_exp2(input int unsigned d, input int unsigned frac);
    int unsigned i, f, t;
    i = d >> frac;
    f = d & ((32'd1 << frac) - 32'd1);
    t = ONE - (f << (14 - frac));
    return (i >= 16) ? '0 : TERM_W'(t >> i);
  endfunction
endpackage

// File: rtl/pseudo_softmax_vec_if.sv
// pseudo_softmax_if: score input stream and probability output stream of the softmax engine.
interface pseudo_softmax_if #(parameter int DATA_W = 8, parameter int OUT_W = 8);
  logic [DATA_W-1:0] in_data;
  logic in_valid, in_last, in_ready;
  logic [OUT_W-1:0] out_data;
  logic out_valid, out_last, out_ready;
  modport master (output in_data, in_valid, in_last, out_ready, input in_ready, out_data, out_valid, out_last);
  modport slave (input in_data, in_valid, in_last, out_ready, output in_ready, out_data, out_valid, out_last);
endinterface

// File: rtl/pseudo_softmax_vec_div.sv
// seq_restoring_div: q = floor(num * 2^Q_W / den) saturated, one quotient bit per cycle.
module seq_restoring_div #(
  parameter int NUM_W = 16,
  parameter int DEN_W = 19,
  parameter int Q_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic [NUM_W-1:0] num,
  input  logic [DEN_W-1:0] den,
  output logic busy,
  output logic done,
  output logic [Q_W-1:0] q
);
  localparam int CW = $clog2(Q_W);
  logic [DEN_W-1:0] r, r_src, r_next, num_ext;
  logic [DEN_W:0] sh;
  logic [Q_W-1:0] qs, qs_src, qs_next;
  logic [CW-1:0] cnt;
  logic sat, sat_src, ge;
  // The first quotient bit is produced on the start edge, so Q_W edges cover all bits.
  always_comb begin
    num_ext = DEN_W'(num);
    r_src = start ? num_ext : r;
    sat_src = start ? (num_ext >= den) : sat;
    qs_src = start ? '0 : qs;
    sh = {r_src, 1'b0};
    ge = sh >= {1'b0, den};
    r_next = ge ? DEN_W'(sh - {1'b0, den}) : sh[DEN_W-1:0];
    qs_next = {qs_src[Q_W-2:0], ge};
    done = busy && cnt == CW'(1);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r <= '0;
      qs <= '0;
      cnt <= '0;
      sat <= 1'b0;
      busy <= 1'b0;
      q <= '0;
    end else if (start || busy) begin
      r <= r_next;
      qs <= qs_next;
      sat <= sat_src;
      cnt <= start ? CW'(Q_W - 1) : cnt - 1'b1;
      busy <= !done;
      if (done) q <= sat_src ? '1 : qs_next;
    end
  end
endmodule

// File: rtl/pseudo_softmax_vec.sv
// pseudo_softmax_vec: buffers a score vector, sums base-2 exponentials relative to its max,
// then streams each normalised probability out through a sequential divider.
module pseudo_softmax_vec import pseudo_softmax_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int FRAC = 4,
  parameter int MAX_N = 8,
  parameter int OUT_W = 8
) (
  input logic clk,
  input logic rst_n,
  pseudo_softmax_if.slave bus
);
  localparam int IDX_W = $clog2(MAX_N);
  localparam int SUM_W = TERM_W + $clog2(MAX_N);
  state_t state, nxt;
  logic [IDX_W-1:0] cnt, idx;
  logic [DATA_W-1:0] mx;
  logic [SUM_W-1:0] sum;
  logic [DATA_W-1:0] score_buf [MAX_N];
  logic [TERM_W-1:0] term_buf [MAX_N];
  logic [TERM_W-1:0] term;
  logic [OUT_W-1:0] q;
  logic hs, at_end, start, busy, done, last_r;
  assign hs = bus.in_valid && state == LOAD;
  assign at_end = idx == cnt;
  assign term = pwl_exp2(32'(mx - score_buf[idx]), FRAC);
  assign start = state == DIV && !busy;
  assign bus.in_ready = state == LOAD;
  assign bus.out_valid = state == OUT;
  assign bus.out_data = q;
  assign bus.out_last = last_r;
  seq_restoring_div #(.NUM_W(TERM_W), .DEN_W(SUM_W), .Q_W(OUT_W)) u_div (
    .clk(clk), .rst_n(rst_n), .start(start), .num(term_buf[idx]), .den(sum),
    .busy(busy), .done(done), .q(q)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else state <= nxt;
  end
  always_comb begin
    nxt = state;
    case (state)
      LOAD: if (hs && (bus.in_last || cnt == IDX_W'(MAX_N - 1))) nxt = SUM;
      SUM: if (at_end) nxt = DIV;
      DIV: if (done) nxt = OUT;
      OUT: if (bus.out_ready) nxt = at_end ? LOAD : DIV;
    endcase
  end
  // cnt stops on the final element, so it doubles as the last index of the vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
      mx <= '0;
      sum <= '0;
      last_r <= 1'b0;
    end else begin
      case (state)
        LOAD: if (hs) begin
          mx <= bus.in_data > mx ? bus.in_data : mx;
          if (nxt == LOAD) cnt <= cnt + 1'b1;
        end
        SUM: begin
          sum <= sum + SUM_W'(term);
          idx <= at_end ? '0 : idx + 1'b1;
        end
        DIV: if (done) last_r <= at_end;
        OUT: if (bus.out_ready) begin
          last_r <= 1'b0;
          if (at_end) begin
            cnt <= '0;
            idx <= '0;
            mx <= '0;
            sum <= '0;
          end else idx <= idx + 1'b1;
        end
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (hs) score_buf[cnt] <= bus.in_data;
    if (state == SUM) term_buf[idx] <= term;
  end
endmodule
